// File: rtl/ctrl_pipe_hazard.sv
// Pipeline control carrier: ID/EX, EX/MEM, MEM/WB control registers with
// load-use stall, taken-branch flush, EX operand forwarding and event counters.
module ctrl_pipe_hazard #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_regwrite,
   input  logic             id_alusrc,
   input  logic             id_memtoreg,
   input  logic             id_memread,
   input  logic             id_memwrite,
   input  logic             id_branch,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             flush_ifid,
   output logic             ex_regwrite,
   output logic             ex_alusrc,
   output logic             ex_memtoreg,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_branch,
   output logic [REG_W-1:0] ex_rs1,
   output logic [REG_W-1:0] ex_rs2,
   output logic [REG_W-1:0] ex_rd,
   output logic             mem_regwrite,
   output logic             mem_memtoreg,
   output logic             mem_memread,
   output logic             mem_memwrite,
   output logic [REG_W-1:0] mem_rd,
   output logic             wb_regwrite,
   output logic             wb_memtoreg,
   output logic [REG_W-1:0] wb_rd,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b01;

   logic             r_ex_regwrite, r_ex_alusrc, r_ex_memtoreg;
   logic             r_ex_memread, r_ex_memwrite, r_ex_branch;
   logic [REG_W-1:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
   logic             r_mem_regwrite, r_mem_memtoreg, r_mem_memread, r_mem_memwrite;
   logic [REG_W-1:0] r_mem_rd;
   logic             r_wb_regwrite, r_wb_memtoreg;
   logic [REG_W-1:0] r_wb_rd;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   logic             w_load_use, w_take, w_stall, w_bubble;
   logic [1:0]       w_fwd_a, w_fwd_b;

   // Newest producer wins; x0 is hard-wired zero and never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] rs,
      input logic             m_rw,
      input logic [REG_W-1:0] m_rd,
      input logic             w_rw,
      input logic [REG_W-1:0] w_rd
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (m_rw && (m_rd != '0) && (m_rd == rs))
         sel = FWD_MEM;
      else if (w_rw && (w_rd != '0) && (w_rd == rs))
         sel = FWD_WB;
      return sel;
   endfunction

   always_comb begin
      w_load_use = r_ex_memread && (r_ex_rd != '0) && id_valid &&
                   ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
      w_take     = r_ex_branch && ex_branch_taken;
      // The stalled instruction is discarded by a taken branch anyway.
      w_stall    = w_load_use && !w_take;
      w_bubble   = w_take || w_load_use || !id_valid;
      w_fwd_a    = fwd_sel(r_ex_rs1, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
      w_fwd_b    = fwd_sel(r_ex_rs2, r_mem_regwrite, r_mem_rd, r_wb_regwrite, r_wb_rd);
   end

   // ID/EX register: bubble on hazard, flush or empty IF/ID.
   always_ff @(posedge clk) begin
      if (!rst_n || w_bubble) begin
         r_ex_regwrite <= 1'b0;
         r_ex_alusrc   <= 1'b0;
         r_ex_memtoreg <= 1'b0;
         r_ex_memread  <= 1'b0;
         r_ex_memwrite <= 1'b0;
         r_ex_branch   <= 1'b0;
         r_ex_rs1      <= '0;
         r_ex_rs2      <= '0;
         r_ex_rd       <= '0;
      end else begin
         r_ex_regwrite <= id_regwrite;
         r_ex_alusrc   <= id_alusrc;
         r_ex_memtoreg <= id_memtoreg;
         r_ex_memread  <= id_memread;
         r_ex_memwrite <= id_memwrite;
         r_ex_branch   <= id_branch;
         r_ex_rs1      <= id_rs1;
         r_ex_rs2      <= id_rs2;
         r_ex_rd       <= id_rd;
      end
   end

   // EX/MEM and MEM/WB always advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_regwrite <= 1'b0;
         r_mem_memtoreg <= 1'b0;
         r_mem_memread  <= 1'b0;
         r_mem_memwrite <= 1'b0;
         r_mem_rd       <= '0;
         r_wb_regwrite  <= 1'b0;
         r_wb_memtoreg  <= 1'b0;
         r_wb_rd        <= '0;
      end else begin
         r_mem_regwrite <= r_ex_regwrite;
         r_mem_memtoreg <= r_ex_memtoreg;
         r_mem_memread  <= r_ex_memread;
         r_mem_memwrite <= r_ex_memwrite;
         r_mem_rd       <= r_ex_rd;
         r_wb_regwrite  <= r_mem_regwrite;
         r_wb_memtoreg  <= r_mem_memtoreg;
         r_wb_rd        <= r_mem_rd;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_take && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign stall        = w_stall;
   assign flush_ifid   = w_take;
   assign fwd_a        = w_fwd_a;
   assign fwd_b        = w_fwd_b;
   assign ex_regwrite  = r_ex_regwrite;
   assign ex_alusrc    = r_ex_alusrc;
   assign ex_memtoreg  = r_ex_memtoreg;
   assign ex_memread   = r_ex_memread;
   assign ex_memwrite  = r_ex_memwrite;
   assign ex_branch    = r_ex_branch;
   assign ex_rs1       = r_ex_rs1;
   assign ex_rs2       = r_ex_rs2;
   assign ex_rd        = r_ex_rd;
   assign mem_regwrite = r_mem_regwrite;
   assign mem_memtoreg = r_mem_memtoreg;
   assign mem_memread  = r_mem_memread;
   assign mem_memwrite = r_mem_memwrite;
   assign mem_rd       = r_mem_rd;
   assign wb_regwrite  = r_wb_regwrite;
   assign wb_memtoreg  = r_wb_memtoreg;
   assign wb_rd        = r_wb_rd;
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: directed scenarios plus random traffic, all
// checked every cycle against an instruction-level pipeline model.
module tb_ctrl_pipe_hazard;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned REG_W   = 5;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic rw, alusrc, mtr, mr, mw, br;
      logic [REG_W-1:0] rs1, rs2, rd;
   } instr_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic             id_regwrite, id_alusrc, id_memtoreg, id_memread, id_memwrite, id_branch;
   logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
   logic             ex_branch_taken;
   logic             stall, flush_ifid;
   logic             ex_regwrite, ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite, ex_branch;
   logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd;
   logic             mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite;
   logic [REG_W-1:0] mem_rd;
   logic             wb_regwrite, wb_memtoreg;
   logic [REG_W-1:0] wb_rd;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   ctrl_pipe_hazard #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_regwrite(id_regwrite), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .ex_branch_taken(ex_branch_taken), .stall(stall), .flush_ifid(flush_ifid),
      .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_rd(mem_rd),
      .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int     n_vec = 0;
   int     n_err = 0;
   // Model: m_pipe[0]=EX, [1]=MEM, [2]=WB instruction records.
   instr_t m_pipe [3];
   int     m_scnt, m_fcnt;
   logic   cur_rst, cur_valid, cur_taken;
   instr_t cur_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic instr_t mk(input logic rw, alusrc, mtr, mr, mw, br,
                                 input int rs1, rs2, rd);
      instr_t i;
      i.rw = rw; i.alusrc = alusrc; i.mtr = mtr; i.mr = mr; i.mw = mw; i.br = br;
      i.rs1 = REG_W'(rs1); i.rs2 = REG_W'(rs2); i.rd = REG_W'(rd);
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t i;
      i.rw = 1'($urandom); i.alusrc = 1'($urandom); i.mtr = 1'($urandom);
      i.mr = ($urandom_range(0, 2) == 0); i.mw = 1'($urandom);
      i.br = ($urandom_range(0, 3) == 0);
      i.rs1 = REG_W'($urandom_range(0, 3));
      i.rs2 = REG_W'($urandom_range(0, 3));
      i.rd  = REG_W'($urandom_range(0, 3));
      return i;
   endfunction

   function automatic logic m_load_use();
      return m_pipe[0].mr && (m_pipe[0].rd != 0) && cur_valid &&
             ((m_pipe[0].rd == cur_in.rs1) || (m_pipe[0].rd == cur_in.rs2));
   endfunction

   function automatic logic m_take();
      return m_pipe[0].br && cur_taken;
   endfunction

   function automatic logic [1:0] m_fwd(input logic [REG_W-1:0] rs);
      if (rs == 0) return 2'b00;
      if (m_pipe[1].rw && m_pipe[1].rd == rs) return 2'b10;
      if (m_pipe[2].rw && m_pipe[2].rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic compare_all();
      instr_t e, m, w;
      e = m_pipe[0]; m = m_pipe[1]; w = m_pipe[2];
      check("flush_ifid", 32'(flush_ifid), 32'(m_take()));
      check("stall", 32'(stall), 32'(m_load_use() && !m_take()));
      check("ex_ctrl", 32'({ex_regwrite, ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite, ex_branch}),
            32'({e.rw, e.alusrc, e.mtr, e.mr, e.mw, e.br}));
      check("ex_idx", 32'({ex_rs1, ex_rs2, ex_rd}), 32'({e.rs1, e.rs2, e.rd}));
      check("mem", 32'({mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite, mem_rd}),
            32'({m.rw, m.mtr, m.mr, m.mw, m.rd}));
      check("wb", 32'({wb_regwrite, wb_memtoreg, wb_rd}), 32'({w.rw, w.mtr, w.rd}));
      check("fwd_a", 32'(fwd_a), 32'(m_fwd(e.rs1)));
      check("fwd_b", 32'(fwd_b), 32'(m_fwd(e.rs2)));
      check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      check("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
   endtask

   // Apply one cycle's inputs mid-cycle and check all outputs against the model.
   task automatic drive(input logic rst, input instr_t ins, input logic valid, input logic taken);
      @(negedge clk);
      cur_rst = rst; cur_in = ins; cur_valid = valid; cur_taken = taken;
      rst_n = rst; id_valid = valid; ex_branch_taken = taken;
      id_regwrite = ins.rw; id_alusrc = ins.alusrc; id_memtoreg = ins.mtr;
      id_memread = ins.mr; id_memwrite = ins.mw; id_branch = ins.br;
      id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_rd = ins.rd;
      #1;
      compare_all();
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) m_pipe[i] = '0;
      m_scnt = 0;
      m_fcnt = 0;
   endtask

   // Advance the rising edge and the model by one instruction slot.
   task automatic tick();
      logic lu, tk;
      @(posedge clk);
      if (!cur_rst) begin
         model_clear();
      end else begin
         lu = m_load_use();
         tk = m_take();
         if (lu && !tk && m_scnt < CNT_MAX) m_scnt++;
         if (tk && m_fcnt < CNT_MAX) m_fcnt++;
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = (tk || lu || !cur_valid) ? instr_t'('0) : cur_in;
      end
   endtask

   task automatic do_reset();
      drive(1'b0, rnd_instr(), 1'($urandom), 1'($urandom));
      tick();
   endtask

   instr_t nop, lw6, use7, add3, sub4, c8, brld, lw0, add1;

   initial begin
      nop  = '0;
      lw6  = mk(1, 1, 1, 1, 0, 0, 2, 0, 6);
      use7 = mk(1, 0, 0, 0, 0, 0, 6, 6, 7);
      add3 = mk(1, 0, 0, 0, 0, 0, 1, 2, 3);
      sub4 = mk(1, 0, 0, 0, 0, 0, 3, 5, 4);
      c8   = mk(1, 0, 0, 0, 0, 0, 3, 0, 8);
      brld = mk(0, 0, 0, 1, 0, 1, 1, 2, 6);
      lw0  = mk(1, 1, 1, 1, 0, 0, 2, 0, 0);
      add1 = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);

      // Reset with random inputs: first edge unchecked (state unknown), second checked.
      model_clear();
      rst_n = 1'b0; id_valid = 1'b1; ex_branch_taken = 1'b1;
      {id_regwrite, id_alusrc, id_memtoreg, id_memread, id_memwrite, id_branch} = 6'($urandom);
      id_rs1 = REG_W'($urandom); id_rs2 = REG_W'($urandom); id_rd = REG_W'($urandom);
      @(posedge clk);
      do_reset();
      repeat (3) begin drive(1'b1, nop, 1'b0, 1'b0); tick(); end
      drive(1'b1, nop, 1'b0, 1'b0);
      check("idle_stall_cnt", 32'(stall_cnt), 32'd0);
      check("idle_fwd", 32'({fwd_a, fwd_b}), 32'd0);
      tick();

      // Straight-line flow with EX/MEM then MEM/WB forwarding.
      do_reset();
      drive(1'b1, add3, 1'b1, 1'b0); tick();
      drive(1'b1, sub4, 1'b1, 1'b0); tick();
      drive(1'b1, c8, 1'b1, 1'b0);
      check("flow_mem_rd", 32'({mem_regwrite, mem_rd}), 32'({1'b1, 5'd3}));
      check("flow_fwd_a_mem", 32'(fwd_a), 32'd2);
      check("flow_fwd_b_rf", 32'(fwd_b), 32'd0);
      tick();
      drive(1'b1, nop, 1'b0, 1'b0);
      check("flow_fwd_a_wb", 32'(fwd_a), 32'd1);
      tick();

      // Load-use: one stall cycle, then MEM/WB forwarding of the load.
      do_reset();
      drive(1'b1, lw6, 1'b1, 1'b0); tick();
      drive(1'b1, use7, 1'b1, 1'b0);
      check("lu_stall", 32'(stall), 32'd1);
      tick();
      drive(1'b1, use7, 1'b1, 1'b0);
      check("lu_release", 32'(stall), 32'd0);
      check("lu_bubble", 32'({ex_regwrite, ex_memread, ex_rd}), 32'd0);
      check("lu_cnt", 32'(stall_cnt), 32'd1);
      tick();
      drive(1'b1, nop, 1'b0, 1'b0);
      check("lu_fwd", 32'({fwd_a, fwd_b}), 32'b0101);
      tick();

      // Taken branch with simultaneous load-use: flush wins.
      do_reset();
      drive(1'b1, brld, 1'b1, 1'b0); tick();
      drive(1'b1, use7, 1'b1, 1'b1);
      check("br_flush", 32'(flush_ifid), 32'd1);
      check("br_no_stall", 32'(stall), 32'd0);
      tick();
      drive(1'b1, nop, 1'b0, 1'b0);
      check("br_bubble", 32'({ex_regwrite, ex_branch, ex_memread, ex_rd}), 32'd0);
      check("br_cnts", 32'({flush_cnt, stall_cnt}), 32'({4'd1, 4'd0}));
      tick();

      // x0 destination: no stall, no forwarding.
      do_reset();
      drive(1'b1, lw0, 1'b1, 1'b0); tick();
      drive(1'b1, add1, 1'b1, 1'b0);
      check("x0_no_stall", 32'(stall), 32'd0);
      tick();
      drive(1'b1, nop, 1'b0, 1'b0);
      check("x0_fwd_mem", 32'({fwd_a, fwd_b}), 32'd0);
      tick();
      drive(1'b1, nop, 1'b0, 1'b0);
      check("x0_fwd_wb", 32'({fwd_a, fwd_b}), 32'd0);
      tick();

      // Counter saturation, then reset during an active stall.
      do_reset();
      repeat (20) begin
         drive(1'b1, lw6, 1'b1, 1'b0); tick();
         drive(1'b1, use7, 1'b1, 1'b0); tick();
      end
      drive(1'b1, lw6, 1'b1, 1'b0);
      check("sat_cnt", 32'(stall_cnt), 32'd15);
      tick();
      drive(1'b0, use7, 1'b1, 1'b0);
      check("rst_stall_active", 32'(stall), 32'd1);
      tick();
      drive(1'b1, nop, 1'b0, 1'b0);
      check("rst_cleared", 32'({stall, stall_cnt, ex_memread, ex_rd, mem_rd, wb_rd}), 32'd0);
      tick();

      // Random traffic with occasional resets.
      for (int c = 0; c < 800; c++) begin
         drive(($urandom_range(0, 59) != 0), rnd_instr(),
               ($urandom_range(0, 3) != 0), 1'($urandom));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Consumes the decoded control bits (Regwrite, ALUsrc, Memtoreg, Memread, Memwrite, Branch) produced in ID.
- Carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers with the destination and source register numbers.
- Detects load-use hazards (stall plus bubble) and taken branches (flush).
- Drives forwarding selects for the EX-stage ALU operands and keeps saturating stall/flush event counters.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  IF/ID register holds a real instruction.
- id_regwrite, id_alusrc, id_memtoreg, id_memread, id_memwrite, id_branch  in  1 each  control bits from the control unit.
- id_rs1, id_rs2, id_rd  in  REG_W each  register indices of the ID instruction.
- ex_branch_taken  in  1  branch condition true, as resolved in EX.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_ifid  out  1  replace IF/ID contents with a bubble at the next edge.
- ex_regwrite, ex_alusrc, ex_memtoreg, ex_memread, ex_memwrite, ex_branch  out  1 each  ID/EX control register.
- ex_rs1, ex_rs2, ex_rd  out  REG_W each  ID/EX register indices.
- mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite  out  1 each  EX/MEM control register.
- mem_rd  out  REG_W  EX/MEM destination.
- wb_regwrite, wb_memtoreg  out  1 each  MEM/WB control register.
- wb_rd  out  REG_W  MEM/WB destination.
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (rst_n=0 at a rising edge): every pipeline register, index and counter goes to 0. stall, flush_ifid, fwd_a and fwd_b are then 0 combinationally. Reset overrides stall and flush in the same cycle.
- Combinational hazard terms:
  - load_use = ex_memread & (ex_rd!=0) & id_valid & ((ex_rd==id_rs1) | (ex_rd==id_rs2)).
  - take = ex_branch & ex_branch_taken.
- Outputs: flush_ifid = take; stall = load_use & ~take. A taken branch wins because the stalled instruction is discarded anyway.
- ID/EX update, each edge:
  - If take | load_use | ~id_valid: load a bubble (all six control bits 0, rs1/rs2/rd = 0).
  - Otherwise: load the id_* values.
- EX/MEM and MEM/WB update every edge unconditionally; no stall or flush reaches them.
  - EX/MEM takes ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_rd.
  - MEM/WB takes mem_regwrite, mem_memtoreg, mem_rd.
- Latency: a non-bubbled ID instruction appears on ex_* after 1 edge, mem_* after 2, wb_* after 3.
- Forwarding (combinational from registered state), fwd_a:
  - 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1;
  - else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1;
  - else 00.
  - fwd_b is identical using ex_rs2.
  - EX/MEM has priority when both match, so the newest value wins.
  - x0 is never forwarded.
- Load-use stall length is exactly 1 cycle. After the bubble, ex_memread=0, so stall drops; the dependent instruction then enters EX and obtains the load data through fwd=01 once the load reaches MEM/WB.
- Counters: stall_cnt increments on each edge where stall=1; flush_cnt increments on each edge where flush_ifid=1. Both saturate at all-ones, with no wrap.
- Unknown or illegal opcodes arrive from the control unit as all-zero control bits. They pass through as harmless no-ops and create no hazards, because regwrite=0 and memread=0.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 2 edges with random inputs, then id_valid=0 for 3 edges.
  - Required response: every output 0, counters 0.
- Straight-line pipeline flow:
  - Stimulus: add x3,x1,x2 (regwrite=1, rd=3), followed by sub x4,x3,x5.
  - Required response: the add appears at mem after 2 edges. When the sub reaches EX, fwd_a=10 and fwd_b=00. On the next cycle, with the add in MEM/WB and a new consumer of x3 in EX, fwd_a=01.
- Load-use hazard:
  - Stimulus: lw x6 (memread=1, memtoreg=1, rd=6), then add x7,x6,x6.
  - Required response: stall=1 for exactly one cycle, ID/EX becomes a bubble, stall_cnt=1. The add then enters EX with fwd_a=fwd_b=01.
- Taken branch with simultaneous load-use:
  - Stimulus: ex_branch=1 and ex_branch_taken=1 while a load-use condition is also present.
  - Required response: flush_ifid=1, stall=0, ID/EX becomes a bubble, flush_cnt increments, stall_cnt unchanged.
- x0 destination:
  - Stimulus: lw x0, then add x1,x0,x0.
  - Required response: no stall and fwd_a=fwd_b=00 throughout.
- Counter saturation and reset mid-stream:
  - Stimulus: CNT_W=4; force 20 load-use stalls, then pull rst_n low during an active stall.
  - Required response: stall_cnt holds at 15 and never wraps. After the reset edge, all state is 0 and stall=0.
